stream_mux_rr: RTL and testbench

//  N-channel packet multiplexer with valid/ready handshake. It is the registered,

---
 rtl/stream_mux_rr.sv | 161 ++++++++++++++++
 tb/tb_stream_mux_rr.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel packet multiplexer with valid/ready handshake.
// An internal arbiter (round-robin or fixed priority) picks a channel. The
// grant is held until that channel's packet ends, so packets never interleave.
// One output register stage sits between the selected producer and the consumer.
module stream_mux_rr #(
  parameter  int BUS_WIDTH = 5,
  parameter  int N_CH      = 4,
  parameter  int MODE      = 0,  // 0 = round-robin, 1 = fixed priority
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH*BUS_WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH-1:0]           in_last,
  output logic [N_CH-1:0]           in_ready,
  output logic [BUS_WIDTH-1:0]      out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       grant_q, grant_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BUS_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [SEL_W-1:0]       out_sel_q, out_sel_d;
  logic                   out_valid_q, out_valid_d;

  // Arbiter and handshake signals.
  logic [SEL_W-1:0]       scan_base;
  logic [SEL_W-1:0]       cand_idx;
  int                     cand;
  logic                   win_valid;
  logic [SEL_W-1:0]       win_idx;
  logic                   cur_valid;
  logic [SEL_W-1:0]       cur_grant;
  logic                   cur_last;
  logic [BUS_WIDTH-1:0]   cur_data;
  logic                   stage_free;
  logic                   in_xfer;
  logic [SEL_W-1:0]       next_ptr;

  // Arbitration: first valid channel found scanning upward from the base, with wrap.
  // NOTE: every variable written in a combinational block gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    scan_base = (MODE == 1) ? '0 : rr_ptr_q;
    cand      = 0;
    cand_idx  = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(scan_base) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      cand_idx = SEL_W'(cand);
      if (!win_valid && in_valid[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Current owner of the input side, its ready and the transfer it makes.
  always_comb begin
    cur_valid  = (state_q == LOCK) ? 1'b1 : win_valid;
    cur_grant  = (state_q == LOCK) ? grant_q : win_idx;
    cur_last   = in_last[cur_grant];
    cur_data   = in_data[cur_grant*BUS_WIDTH +: BUS_WIDTH];
    stage_free = !out_valid_q || out_ready;
    in_ready   = '0;
    if (stage_free && cur_valid) in_ready[cur_grant] = 1'b1;
    in_xfer    = in_valid[cur_grant] && in_ready[cur_grant];
    // Pointer moves just past the channel whose packet ends; fixed priority keeps it at 0.
    if (MODE == 1)                  next_ptr = '0;
    else if (cur_grant == LAST_CH)  next_ptr = '0;
    else                            next_ptr = cur_grant + SEL_W'(1);
  end

  // Next-state logic for the IDLE/LOCK packet lock.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (cur_last) begin
            rr_ptr_d = next_ptr;
          end else begin
            grant_d = cur_grant;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (in_xfer && cur_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register stage: load on input transfer, empty on a lone output transfer.
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_data_d  = cur_data;
      out_last_d  = cur_last;
      out_sel_d   = cur_grant;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight packet.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scenario tasks plus randomized traffic for stream_mux_rr.
// Producers are per-channel word queues; a behavioural model predicts every
// cycle's outputs and ready vector. A second instance runs in fixed priority.
module tb_stream_mux_rr;

  localparam int BW  = 5;
  localparam int NCH = 4;

  typedef logic [BW:0] word_t;  // {last, data}

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NCH*BW-1:0] in_data   = '0;
  logic [NCH-1:0]    in_valid  = '0;
  logic [NCH-1:0]    in_last   = '0;
  logic              out_ready = 1'b1;
  logic [NCH-1:0]    in_ready, in_ready1;
  logic [BW-1:0]     out_data, out_data1;
  logic              out_last, out_last1;
  logic [1:0]        out_sel, out_sel1;
  logic              out_valid, out_valid1;
  logic              busy, busy1;

  int total = 0;
  int bad   = 0;

  word_t       q [NCH][$];
  logic [NCH-1:0] stall = '0;
  logic [6:0]  obs [$];  // {sel, data} of each word the consumer accepted

  always #5 clk = ~clk;

  stream_mux_rr #(.BUS_WIDTH(BW), .N_CH(NCH), .MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  stream_mux_rr #(.BUS_WIDTH(BW), .N_CH(NCH), .MODE(1)) dut_prio (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .out_data(out_data1),
    .out_last(out_last1), .out_sel(out_sel1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1)
  );

  // ---------------- behavioural model (round-robin instance) ----------------
  logic           m_locked, m_ov, m_ol, m_own_v;
  logic [1:0]     m_lock_ch, m_ptr, m_os, m_own, m_idx;
  logic [BW-1:0]  m_od;
  logic [NCH-1:0] m_rdy;

  // Who owns the input side this cycle, and which ready bit that implies.
  always_comb begin
    m_own_v = m_locked;
    m_own   = m_lock_ch;
    m_idx   = '0;
    if (!m_locked) begin
      for (int i = 0; i < NCH; i++) begin
        m_idx = m_ptr + 2'(i);  // 2-bit sum wraps channel 3 -> 0
        if (!m_own_v && in_valid[m_idx]) begin
          m_own_v = 1'b1;
          m_own   = m_idx;
        end
      end
    end
    m_rdy = '0;
    if (m_own_v && (!m_ov || out_ready)) m_rdy[m_own] = 1'b1;
  end

  // Model update on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0; m_lock_ch <= '0; m_ptr <= '0;
      m_ov <= 1'b0; m_od <= '0; m_ol <= 1'b0; m_os <= '0;
    end else if (|(m_rdy & in_valid)) begin
      m_ov      <= 1'b1;
      m_od      <= in_data[m_own*BW +: BW];
      m_ol      <= in_last[m_own];
      m_os      <= m_own;
      m_locked  <= !in_last[m_own];
      m_lock_ch <= m_own;
      if (in_last[m_own]) m_ptr <= m_own + 2'd1;
    end else if (out_ready) begin
      m_ov <= 1'b0;
    end
  end

  logic [13:0] dut_vec, mdl_vec;
  assign dut_vec = {out_valid, out_data, out_last, out_sel, busy, in_ready};
  assign mdl_vec = {m_ov, m_od, m_ol, m_os, m_locked, m_rdy};

  // ---------------- stimulus plumbing ----------------
  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (q[k].size() > 0) begin
        in_valid[2'(k)]       = !stall[2'(k)];
        in_last[2'(k)]        = q[k][0][BW];
        in_data[k*BW +: BW]   = q[k][0][BW-1:0];
      end else begin
        in_valid[2'(k)]       = 1'b0;
        in_last[2'(k)]        = 1'b0;
        in_data[k*BW +: BW]   = '0;
      end
    end
  endtask

  // Called between a negedge and the next posedge: records transfers, steps one cycle.
  task automatic advance();
    logic [NCH-1:0] xf;
    xf = m_rdy & in_valid;
    if (out_valid && out_ready) obs.push_back({out_sel, out_data});
    @(posedge clk); #1;
    for (int k = 0; k < NCH; k++) if (xf[2'(k)]) void'(q[k].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    all_empty = 1'b1;
    for (int k = 0; k < NCH; k++) if (q[k].size() != 0) all_empty = 1'b0;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; stall = '0; drive();
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL reset_rr got=%h want=0", dut_vec);
    end
    total++;
    if ({out_valid1, out_data1, out_last1, out_sel1, busy1, in_ready1} !== 14'h0) begin
      bad++; $display("FAIL reset_prio got=%h want=0",
                      {out_valid1, out_data1, out_last1, out_sel1, busy1, in_ready1});
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_single_words();
    for (int k = 0; k < NCH; k++) q[k].push_back({1'b1, 5'(k + 1)});
    drive();
    for (int i = 0; i <= NCH; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL single_model got=%h want=%h", dut_vec, mdl_vec);
      end
      if (i < NCH) begin
        total++;
        if (in_ready !== (4'b0001 << i)) begin
          bad++; $display("FAIL single_ready got=%b want=%b", in_ready, 4'b0001 << i);
        end
      end
      if (i > 0) begin
        total++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'(i - 1), 5'(i)}) begin
          bad++; $display("FAIL single_out got=%h want=%h",
                          {out_valid, out_sel, out_data}, {1'b1, 2'(i - 1), 5'(i)});
        end
      end
      advance();
    end
  endtask

  task automatic test_locked_packet();
    logic [6:0] exp_w [4];
    exp_w[0] = {2'd1, 5'h0A}; exp_w[1] = {2'd1, 5'h0B};
    exp_w[2] = {2'd1, 5'h0C}; exp_w[3] = {2'd2, 5'h12};
    obs.delete();
    q[1].push_back({1'b0, 5'h0A}); q[1].push_back({1'b0, 5'h0B});
    q[1].push_back({1'b1, 5'h0C}); q[2].push_back({1'b1, 5'h12});
    drive();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL lock_model got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (obs.size() != 4) begin
      bad++; $display("FAIL lock_count got=%0d want=4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs[i] !== exp_w[i]) begin
          bad++; $display("FAIL lock_order[%0d] got=%h want=%h", i, obs[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] exp_w [3];
    exp_w[0] = {2'd3, 5'h15}; exp_w[1] = {2'd0, 5'h07}; exp_w[2] = {2'd1, 5'h09};
    obs.delete();
    out_ready = 1'b0;
    q[3].push_back({1'b1, 5'h15}); q[0].push_back({1'b1, 5'h07});
    q[1].push_back({1'b1, 5'h09});
    drive();
    @(negedge clk);
    total++;
    if (dut_vec !== mdl_vec) begin
      bad++; $display("FAIL bp_first got=%h want=%h", dut_vec, mdl_vec);
    end
    advance();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 5'h15, 4'b0000}) begin
        bad++; $display("FAIL bp_hold got=%h want=%h", {out_valid, out_data, in_ready},
                        {1'b1, 5'h15, 4'b0000});
      end
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL bp_model got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL bp_resume got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (obs.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d want=3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== exp_w[i]) begin
          bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, obs[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [BW-1:0] ch0_front;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < 6; j++) q[k].push_back({1'b1, 5'(k * 6 + j + 1)});
    drive();
    ch0_front = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL prio_rr_model got=%h want=%h", dut_vec, mdl_vec);
      end
      total++;
      if (in_ready1 !== 4'b0001) begin
        bad++; $display("FAIL prio_ready got=%b want=0001", in_ready1);
      end
      if (i > 0) begin
        total++;
        if ({out_valid1, out_sel1, out_last1, busy1, out_data1} !==
            {1'b1, 2'd0, 1'b1, 1'b0, ch0_front}) begin
          bad++; $display("FAIL prio_out got=%h want=%h",
                          {out_valid1, out_sel1, out_last1, busy1, out_data1},
                          {1'b1, 2'd0, 1'b1, 1'b0, ch0_front});
        end
      end
      ch0_front = q[0][0][BW-1:0];
      advance();
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL prio_drain got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (!all_empty()) begin
      bad++; $display("FAIL prio_timeout got=pending want=empty");
    end
  endtask

  task automatic test_reset_mid_packet();
    q[3].push_back({1'b0, 5'h1C}); q[3].push_back({1'b0, 5'h1D});
    q[3].push_back({1'b0, 5'h1E}); q[3].push_back({1'b1, 5'h1F});
    drive();
    for (int i = 0; i < 10 && q[3].size() > 2; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL rstmid_model got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (q[3].size() != 2) begin
      bad++; $display("FAIL rstmid_timeout got=%0d want=2", q[3].size());
    end
    rst_n = 1'b0;
    for (int k = 0; k < NCH; k++) q[k].delete();
    drive();
    #1;
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL rstmid_async got=%h want=0", dut_vec);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) q[k].push_back({1'b1, 5'(k + 20)});
    drive();
    @(negedge clk);
    total++;
    if ({busy, in_ready} !== 5'b0_0001) begin
      bad++; $display("FAIL rstmid_first got=%b want=00001", {busy, in_ready});
    end
    advance();
    @(negedge clk);
    total++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 5'd20}) begin
      bad++; $display("FAIL rstmid_ch0 got=%h want=%h", {out_valid, out_sel, out_data},
                      {1'b1, 2'd0, 5'd20});
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL rstmid_drain got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
  endtask

  task automatic test_lock_stall();
    logic [6:0] exp_w [4];
    exp_w[0] = {2'd2, 5'h03}; exp_w[1] = {2'd2, 5'h04};
    exp_w[2] = {2'd2, 5'h05}; exp_w[3] = {2'd0, 5'h11};
    obs.delete();
    out_ready = 1'b1;
    q[2].push_back({1'b0, 5'h03}); q[2].push_back({1'b0, 5'h04});
    q[2].push_back({1'b1, 5'h05});
    drive();
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL stall_grant got=%b want=0100", in_ready);
    end
    q[0].push_back({1'b1, 5'h11});
    stall = 4'b0100;
    advance();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({busy, in_ready} !== 5'b1_0100) begin
        bad++; $display("FAIL stall_hold got=%b want=10100", {busy, in_ready});
      end
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL stall_model got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    stall = '0;
    drive();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL stall_resume got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (obs.size() != 4) begin
      bad++; $display("FAIL stall_count got=%0d want=4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs[i] !== exp_w[i]) begin
          bad++; $display("FAIL stall_order[%0d] got=%h want=%h", i, obs[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL rand_model cyc=%0d got=%h want=%h", c, dut_vec, mdl_vec);
      end
      advance();
      for (int k = 0; k < NCH; k++) begin
        if (q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) q[k].push_back({(j == len - 1), 5'($urandom)});
        end
        stall[2'(k)] = ($urandom_range(0, 7) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drive();
    end
    stall = '0; out_ready = 1'b1; drive();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== mdl_vec) begin
        bad++; $display("FAIL rand_drain got=%h want=%h", dut_vec, mdl_vec);
      end
      advance();
    end
    total++;
    if (!all_empty()) begin
      bad++; $display("FAIL rand_timeout got=pending want=empty");
    end
  endtask

  initial begin
    test_reset();
    test_single_words();
    test_locked_packet();
    test_backpressure();
    test_priority();
    test_reset_mid_packet();
    test_lock_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
